// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared definitions for the round-robin decoder arbiter: channel count,
// select width, FSM state type and the round-robin winner search.
`timescale 1ns/1ps
package dec_arb_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // Pick the first requesting channel after `last`, wrapping past channel 7.
    function automatic logic [SEL_W-1:0] next_rr(input logic [N_CH-1:0]  req,
                                                 input logic [SEL_W-1:0] last);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] win;
        logic             found;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = last + SEL_W'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Requester/arbiter bundle: level requests and release strobe in,
// decoder enable/select, one-hot grant and status out.
`timescale 1ns/1ps
interface decoder_rr_arbiter_if;
    import dec_arb_pkg::*;

    logic [N_CH-1:0]  req_i;
    logic             done_i;
    logic             en_o;
    logic [SEL_W-1:0] sel_o;
    logic [N_CH-1:0]  grant_o;
    logic             busy_o;
    logic             timeout_o;

    modport master (
        output req_i, done_i,
        input  en_o, sel_o, grant_o, busy_o, timeout_o
    );

    modport slave (
        input  req_i, done_i,
        output en_o, sel_o, grant_o, busy_o, timeout_o
    );

endinterface

// File: rtl/decoder_rr_arbiter_dec.sv
// 3-to-8 decoder with enable: the shared select path owned by the arbiter.
`timescale 1ns/1ps
module decoder_3_8 (
    input  logic       en,
    input  logic [2:0] din,
    output logic [7:0] dout
);

    // One-hot decode of din, forced to zero while disabled.
    always_comb begin
        dout = '0;
        if (en) begin
            dout[din] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for 8 requesters sharing one decoder_3_8.
// The winner index and enable are registered and drive the decoder, whose
// one-hot output is the grant vector. Optional macro DEC_ARB_TIMEOUT_EN adds
// a hold counter that forces release after HOLD_MAX grant cycles.
`timescale 1ns/1ps
module decoder_rr_arbiter
    import dec_arb_pkg::*;
#(
    parameter  int HOLD_MAX = 16,
    localparam int CNT_W    = $clog2(HOLD_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder_rr_arbiter_if.slave  bus
);

    arb_state_t       state;
    logic             en_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] last_q;
    logic             tmo_q;
    logic             release_now;

    // Owner gives up the grant by strobing done or dropping its own request.
    assign release_now = bus.done_i | ~bus.req_i[sel_q];

`ifdef DEC_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             hold_expired;

    assign hold_expired = (cnt_q == CNT_W'(HOLD_MAX - 1));

    // Arbiter FSM with hold counter: search in IDLE, hold/release/timeout in GRANT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            en_q   <= 1'b0;
            sel_q  <= '0;
            last_q <= SEL_W'(N_CH - 1);
            tmo_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            tmo_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req_i) begin
                        sel_q <= next_rr(bus.req_i, last_q);
                        en_q  <= 1'b1;
                        state <= GRANT;
                        cnt_q <= '0;
                    end
                end
                GRANT: begin
                    if (release_now || hold_expired) begin
                        en_q   <= 1'b0;
                        last_q <= sel_q;
                        state  <= IDLE;
                        tmo_q  <= ~release_now;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    // Hold length is unbounded in this build, so the limit goes unused.
    logic unused_hold_cfg;
    assign unused_hold_cfg = ((HOLD_MAX + CNT_W) > 0);

    // Arbiter FSM: search in IDLE, hold until released in GRANT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            en_q   <= 1'b0;
            sel_q  <= '0;
            last_q <= SEL_W'(N_CH - 1);
            tmo_q  <= 1'b0;
        end else begin
            tmo_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req_i) begin
                        sel_q <= next_rr(bus.req_i, last_q);
                        en_q  <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        en_q   <= 1'b0;
                        last_q <= sel_q;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

    assign bus.en_o      = en_q;
    assign bus.sel_o     = sel_q;
    assign bus.busy_o    = (state == GRANT);
    assign bus.timeout_o = tmo_q;

    decoder_3_8 u_dec (
        .en   (en_q),
        .din  (sel_q),
        .dout (bus.grant_o)
    );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter with a behavioural reference model.
`timescale 1ns/1ps
module tb_decoder_rr_arbiter;

    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    decoder_rr_arbiter_if bus ();

    decoder_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the shared decoder and which pointer is next.
    bit       m_busy;
    int       m_owner;
    int       m_last;
    bit       m_tmo;
    int       m_held;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  = 0;
            m_owner = 0;
            m_last  = 7;
            m_tmo   = 0;
            m_held  = 0;
        end else if (!m_busy) begin
            m_tmo = 0;
            if (bus.req_i != 8'h00) begin
                for (int k = 1; k <= 8; k++) begin
                    if (!m_busy && bus.req_i[(m_last + k) % 8]) begin
                        m_owner = (m_last + k) % 8;
                        m_busy  = 1;
                    end
                end
                m_held = 1;
            end
        end else begin
            m_tmo = 0;
            if (bus.done_i || !bus.req_i[m_owner]) begin
                m_busy = 0;
                m_last = m_owner;
`ifdef DEC_ARB_TIMEOUT_EN
            end else if (m_held >= HOLD) begin
                m_busy = 0;
                m_last = m_owner;
                m_tmo  = 1;
`endif
            end else begin
                m_held = m_held + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        logic [7:0] exp_grant;
        exp_grant = m_busy ? (8'h01 << m_owner) : 8'h00;
        chk("model_en",      32'(bus.en_o),      32'(m_busy));
        chk("model_sel",     32'(bus.sel_o),     32'(m_owner));
        chk("model_grant",   32'(bus.grant_o),   32'(exp_grant));
        chk("model_busy",    32'(bus.busy_o),    32'(m_busy));
        chk("model_timeout", 32'(bus.timeout_o), 32'(m_tmo));
    endtask

    // Apply inputs at a falling edge, let one rising edge pass, then compare.
    task automatic tick(input logic [7:0] r, input logic d);
        bus.req_i  = r;
        bus.done_i = d;
        @(negedge clk);
        cmp_model();
    endtask

    task automatic lit(input string name, input logic [7:0] exp);
        chk(name, 32'(bus.grant_o), 32'(exp));
    endtask

    initial begin
        bus.req_i  = 8'hFF;
        bus.done_i = 1'b0;
        // Reset held for two edges with every channel requesting.
        @(negedge clk);
        @(negedge clk);
        cmp_model();
        lit("rst_grant", 8'h00);
        chk("rst_en", 32'(bus.en_o), 32'h0);
        rst = 1'b0;
        tick(8'hFF, 1'b0); lit("first_grant", 8'h01);

        // Two requesters alternating, done pulsed on each grant.
        tick(8'h05, 1'b1); lit("alt_gap0", 8'h00);
        tick(8'h05, 1'b0); lit("alt_ch2", 8'h04);
        tick(8'h05, 1'b1); lit("alt_gap1", 8'h00);
        tick(8'h05, 1'b0); lit("alt_ch0", 8'h01);
        tick(8'h05, 1'b1); lit("alt_gap2", 8'h00);
        tick(8'h05, 1'b0); lit("alt_ch2b", 8'h04);

        // Pointer wrap between channel 7 and channel 0.
        tick(8'h81, 1'b1); lit("wrap_gap0", 8'h00);
        tick(8'h81, 1'b0); lit("wrap_ch7", 8'h80);
        tick(8'h81, 1'b1); lit("wrap_gap1", 8'h00);
        tick(8'h81, 1'b0); lit("wrap_ch0", 8'h01);
        tick(8'h81, 1'b1); lit("wrap_gap2", 8'h00);
        tick(8'h81, 1'b0); lit("wrap_ch7b", 8'h80);
        tick(8'h81, 1'b1); lit("wrap_gap3", 8'h00);

        // Owner drops its request, then a stray done while idle.
        tick(8'h81, 1'b0); lit("drop_ch0", 8'h01);
        tick(8'h80, 1'b0); lit("drop_rel", 8'h00);
        tick(8'h00, 1'b0); lit("idle_none", 8'h00);
        tick(8'h00, 1'b1); lit("idle_done", 8'h00);
        chk("idle_done_busy", 32'(bus.busy_o), 32'h0);

        // Long hold by a single requester with done low.
        tick(8'h02, 1'b0); lit("hold_c0", 8'h02);
`ifdef DEC_ARB_TIMEOUT_EN
        tick(8'h02, 1'b0); lit("hold_c1", 8'h02);
        tick(8'h02, 1'b0); lit("hold_c2", 8'h02);
        tick(8'h02, 1'b0); lit("hold_c3", 8'h02);
        tick(8'h02, 1'b0); lit("tmo_gap", 8'h00);
        chk("tmo_pulse", 32'(bus.timeout_o), 32'h1);
        tick(8'h02, 1'b0); lit("tmo_regrant", 8'h02);
        chk("tmo_pulse_end", 32'(bus.timeout_o), 32'h0);
`else
        for (int i = 0; i < 22; i++) begin
            tick(8'h02, 1'b0); lit("hold_long", 8'h02);
            chk("hold_no_tmo", 32'(bus.timeout_o), 32'h0);
        end
`endif
        tick(8'h00, 1'b0); lit("hold_rel", 8'h00);

        // Mid-grant reset, then the pointer search restarts at channel 0.
        tick(8'h08, 1'b0); lit("pre_rst_ch3", 8'h08);
        tick(8'h08, 1'b0); lit("pre_rst_hold", 8'h08);
        rst = 1'b1;
        tick(8'h08, 1'b0); lit("mid_rst", 8'h00);
        chk("mid_rst_en", 32'(bus.en_o), 32'h0);
        rst = 1'b0;
        tick(8'h08, 1'b0); lit("post_rst_ch3", 8'h08);
        chk("post_rst_sel", 32'(bus.sel_o), 32'h3);
        tick(8'h0C, 1'b1); lit("post_rst_gap", 8'h00);
        tick(8'h0C, 1'b0); lit("post_rst_ch2", 8'h04);
        tick(8'h00, 1'b0); lit("end_idle", 8'h00);
        tick(8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
